// File: rtl/sdram_pattern_pkg.sv
// Shared types and constants for the SDRAM pattern tester.
package sdram_pattern_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_INC  = 2'd0,
    PAT_LFSR = 2'd1,
    PAT_ALT  = 2'd2,
    PAT_WALK = 2'd3
  } pattern_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR sit at bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sdram_pattern_master_pattern_gen.sv
// Per-word test pattern generator; data_o is the pattern for the current word index.
module pattern_gen
  import sdram_pattern_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              advance_i,
  input  pattern_e          pattern_i,
  output logic [DATA_W-1:0] data_o
);

  logic [15:0] idx_q, idx_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] word;

  always_comb begin
    idx_d  = idx_q;
    lfsr_d = lfsr_q;
    if (clear_i) begin
      idx_d  = '0;
      lfsr_d = LFSR_SEED;
    end else if (advance_i) begin
      idx_d  = idx_q + 16'd1;
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      idx_q  <= idx_d;
      lfsr_q <= lfsr_d;
    end
  end

  always_comb begin
    word = idx_q;
    unique case (pattern_i)
      PAT_INC:  word = idx_q;
      PAT_LFSR: word = lfsr_q;
      PAT_ALT:  word = idx_q[0] ? 16'hAAAA : 16'h5555;
      PAT_WALK: word = 16'd1 << idx_q[3:0];
    endcase
  end

  assign data_o = DATA_W'(word);

endmodule

// File: rtl/sdram_pattern_master.sv
// Avalon-MM master that writes a pattern over an SDRAM word range, reads it back
// with pipelined reads and reports mismatch statistics.
module sdram_pattern_master
  import sdram_pattern_pkg::*;
#(
  parameter int unsigned ADDR_W   = 25,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned LEN_W    = 24
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     cfg_base,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [1:0]            cfg_pattern,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [9:0]            leds
);

  localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);

  state_e              state_q, state_d;
  pattern_e            pat_q, pat_d;
  logic [ADDR_W-1:0]   base_q, base_d, ferr_q, ferr_d;
  logic [LEN_W-1:0]    len_q, len_d, idx_q, idx_d, rx_q, rx_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [15:0]         err_q, err_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [DATA_W-1:0]   iss_data, rsp_data;
  logic                go, wr_acc, rd_acc, rsp_in, last_idx;

  assign go       = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign wr_acc   = avm_write && !avm_waitrequest;
  assign rd_acc   = avm_read && !avm_waitrequest;
  assign rsp_in   = avm_readdatavalid && (state_q == ST_READ || state_q == ST_DRAIN)
                    && (rx_q != len_q);
  assign last_idx = (idx_q == len_q - LEN_W'(1));

  // Issue-side generator restarts at the WRITE->READ turn so it is ready for reuse.
  pattern_gen #(.DATA_W(DATA_W)) u_iss_gen (
    .clk_i     (clk_clk),
    .rst_ni    (reset_reset_n),
    .clear_i   (go || (wr_acc && last_idx)),
    .advance_i (wr_acc),
    .pattern_i (pat_q),
    .data_o    (iss_data)
  );

  pattern_gen #(.DATA_W(DATA_W)) u_rsp_gen (
    .clk_i     (clk_clk),
    .rst_ni    (reset_reset_n),
    .clear_i   (go),
    .advance_i (rsp_in),
    .pattern_i (pat_q),
    .data_o    (rsp_data)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rx_d    = rx_q;
    pend_d  = pend_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (go) begin
      base_d = cfg_base & ~ADDR_W'(1);
      len_d  = cfg_len;
      pat_d  = pattern_e'(cfg_pattern);
      idx_d  = '0;
      rx_d   = '0;
      pend_d = '0;
      err_d  = '0;
      ferr_d = '0;
      if (cfg_len == '0) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end else begin
        state_d = ST_WRITE;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        ST_WRITE: if (wr_acc) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = ST_READ;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
        ST_READ: if (rd_acc) begin
          idx_d = idx_q + LEN_W'(1);
          if (last_idx) state_d = ST_DRAIN;
        end
        ST_DRAIN: if (rx_q == len_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0);
        end
        default: ;
      endcase
      pend_d = pend_q + PEND_W'(rd_acc) - PEND_W'(rsp_in);
      if (rsp_in) begin
        rx_d = rx_q + LEN_W'(1);
        if (avm_readdata != rsp_data) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (err_q == '0) ferr_d = base_q + (ADDR_W'(rx_q) << 1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_INC;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      rx_q    <= '0;
      pend_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      rx_q    <= rx_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign avm_write      = (state_q == ST_WRITE);
  assign avm_read       = (state_q == ST_READ) && (pend_q < PEND_W'(MAX_PEND));
  assign avm_address    = base_q + (ADDR_W'(idx_q) << 1);
  assign avm_writedata  = iss_data;
  assign avm_byteenable = '1;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign leds           = {err_q[5:0], done_q & ~pass_q, pass_q, done_q, busy_q};

endmodule

// File: tb/tb_sdram_pattern_master.sv
// Scoreboard bench: a behavioural Avalon slave/monitor checks every bus transfer
// against queued expectations; final status is checked against a pattern model.
module tb_sdram_pattern_master;

  localparam int unsigned MAX_PEND = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [24:0] cfg_base = '0;
  logic [23:0] cfg_len = '0;
  logic [1:0]  cfg_pattern = '0;
  logic [24:0] avm_address;
  logic        avm_read, avm_write;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [15:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [24:0] first_err_addr;
  logic [9:0]  leds;

  sdram_pattern_master #(
    .ADDR_W(25), .DATA_W(16), .MAX_PEND(MAX_PEND), .LEN_W(24)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .leds(leds)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic [24:0] a; logic [15:0] d; } wr_t;
  typedef struct { int unsigned due; logic [15:0] d; } rsp_t;

  wr_t         exp_wr[$];
  logic [24:0] exp_rd[$];
  rsp_t        rsp_q[$];
  logic [15:0] mem [logic [24:0]];

  int          errors = 0, checks = 0;
  int          wait_pct = 0, c0 = -1, c1 = -1, rd_seen = 0, rd_base = 0;
  int unsigned lat_lo = 1, lat_hi = 1, cyc = 0, pend = 0, max_pend_seen = 0, bus_pulses = 0;
  int          exp_err_g = 0;
  logic [24:0] exp_ferr_g = '0;
  logic        prev_wstall = 1'b0, prev_rstall = 1'b0;
  logic [24:0] prev_addr = '0;
  logic [15:0] prev_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pattern value of word k, straight from the pattern definitions.
  function automatic logic [15:0] pat_word(input int p, input int unsigned k);
    int unsigned s, fb;
    case (p)
      0: return 16'(k);
      1: begin
        s = 32'hACE1;
        for (int unsigned i = 0; i < k; i++) begin
          fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
          s  = (s >> 1) | (fb << 15);
        end
        return 16'(s);
      end
      2: return (k % 2 == 0) ? 16'h5555 : 16'hAAAA;
      default: return 16'(32'd1 << (k % 16));
    endcase
  endfunction

  task automatic monitor();
    rsp_t        r;
    wr_t         w;
    logic        stall;
    int          idx;
    logic [15:0] d;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rsp_q.delete(); exp_wr.delete(); exp_rd.delete();
        pend = 0; prev_wstall = 1'b0; prev_rstall = 1'b0;
        avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
      end else begin
        avm_readdatavalid = 1'b0;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
          r = rsp_q.pop_front();
          avm_readdata = r.d; avm_readdatavalid = 1'b1; pend--;
        end
        if (prev_wstall) begin
          chk("wr_hold_write", avm_write, 1);
          chk("wr_hold_addr", avm_address, prev_addr);
          chk("wr_hold_data", avm_writedata, prev_data);
        end
        if (prev_rstall) begin
          chk("rd_hold_read", avm_read, 1);
          chk("rd_hold_addr", avm_address, prev_addr);
        end
        stall = ($urandom_range(99, 0) < wait_pct);
        avm_waitrequest = stall;
        if (avm_write || avm_read) bus_pulses++;
        prev_wstall = avm_write && stall;
        prev_rstall = avm_read && stall;
        prev_addr = avm_address;
        prev_data = avm_writedata;
        if (avm_write && !stall) begin
          mem[avm_address] = avm_writedata;
          chk("write_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            chk("wr_addr", avm_address, w.a);
            chk("wr_data", avm_writedata, w.d);
          end
        end
        if (avm_read && !stall) begin
          chk("read_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) chk("rd_addr", avm_address, exp_rd.pop_front());
          idx = rd_seen - rd_base;
          rd_seen++;
          d = mem.exists(avm_address) ? mem[avm_address] : 16'h0000;
          if (idx == c0 || idx == c1) d ^= 16'h0100;
          r.due = cyc + $urandom_range(lat_hi, lat_lo);
          r.d = d;
          rsp_q.push_back(r);
          pend++;
          chk("outstanding_le_max", pend <= MAX_PEND, 1);
          if (pend > max_pend_seen) max_pend_seen = pend;
        end
        cyc++;
      end
    end
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_read"}, avm_read, 0);
    chk({nm, "_write"}, avm_write, 0);
    chk({nm, "_addr"}, avm_address, 0);
    chk({nm, "_wdata"}, avm_writedata, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_errcnt"}, err_count, 0);
    chk({nm, "_ferr"}, first_err_addr, 0);
    chk({nm, "_leds"}, leds, 0);
  endtask

  task automatic start_test(input string nm, input logic [24:0] base, input int unsigned len,
                            input int pat, input int wp, input int unsigned llo,
                            input int unsigned lhi, input int k0, input int k1);
    logic [24:0] b, a;
    int unsigned p0;
    wait_pct = wp; lat_lo = llo; lat_hi = lhi; c0 = k0; c1 = k1;
    b = base & ~25'h1;
    exp_err_g = 0; exp_ferr_g = '0; max_pend_seen = 0; rd_base = rd_seen;
    for (int unsigned i = 0; i < len; i++) begin
      a = b + 25'(2 * i);
      exp_wr.push_back('{a, pat_word(pat, i)});
      exp_rd.push_back(a);
      if (int'(i) == k0 || int'(i) == k1) begin
        if (exp_err_g == 0) exp_ferr_g = a;
        exp_err_g++;
      end
    end
    @(negedge clk);
    cfg_base = base; cfg_len = 24'(len); cfg_pattern = 2'(pat); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      chk({nm, "_done_next"}, done, 1);
      chk({nm, "_pass"}, pass, 1);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_errcnt"}, err_count, 0);
      p0 = bus_pulses;
      repeat (4) @(negedge clk);
      chk({nm, "_bus_pulses"}, bus_pulses - p0, 0);
    end else begin
      chk({nm, "_first_write_latency"}, avm_write, 1);
      chk({nm, "_busy_next"}, busy, 1);
      chk({nm, "_done_cleared"}, done, 0);
    end
  endtask

  task automatic finish_test(input string nm, input bit poke, input int exp_maxpend);
    int n;
    logic [9:0] el;
    logic ep;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      if (poke && n == 3 && busy) begin
        cfg_base = 25'h1230; cfg_len = 24'd1; cfg_pattern = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    ep = (exp_err_g == 0);
    el = {6'(exp_err_g), ~ep, ep, 1'b1, 1'b0};
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_pass"}, pass, ep);
    chk({nm, "_errcnt"}, err_count, exp_err_g);
    chk({nm, "_ferr"}, first_err_addr, exp_ferr_g);
    chk({nm, "_leds"}, leds, el);
    chk({nm, "_writes_left"}, exp_wr.size(), 0);
    chk({nm, "_reads_left"}, exp_rd.size(), 0);
    chk({nm, "_pending_left"}, pend, 0);
    if (exp_maxpend >= 0) chk({nm, "_max_pending"}, max_pend_seen, exp_maxpend);
  endtask

  initial begin
    int n;
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    reset_checks("reset");
    chk("reset_byteenable", avm_byteenable, 2'b11);
    rst_n = 1'b1;
    @(negedge clk);

    start_test("inc4", 25'h100, 4, 0, 0, 1, 1, -1, -1);
    finish_test("inc4", 0, -1);
    start_test("lfsr8", 25'h2000, 8, 1, 40, 1, 3, -1, -1);
    finish_test("lfsr8", 0, -1);
    start_test("lat6", 25'h40000, 16, 2, 0, 6, 6, -1, -1);
    finish_test("lat6", 0, 4);
    start_test("corrupt", 25'h0, 16, 3, 0, 1, 2, 5, 9);
    finish_test("corrupt", 0, -1);
    start_test("len0", 25'h300, 0, 0, 0, 1, 1, -1, -1);
    start_test("wrap", 25'h1FFFFFB, 6, 1, 25, 1, 2, 4, -1);
    finish_test("wrap", 1, -1);

    start_test("abort", 25'h800, 8, 0, 0, 12, 12, -1, -1);
    n = 0;
    while (pend != 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("abort_three_pending", pend, 3);
    #2 rst_n = 1'b0;
    #1 reset_checks("midread_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_test("after_rst", 25'h500, 2, 1, 0, 1, 2, -1, -1);
    finish_test("after_rst", 0, -1);

    for (int t = 0; t < 6; t++) begin
      logic [24:0] rb;
      int unsigned rl;
      rb = 25'($urandom);
      rl = $urandom_range(24, 1);
      start_test("rand", rb, rl, int'($urandom_range(3, 0)), int'($urandom_range(60, 0)),
                 1, $urandom_range(5, 1), int'($urandom_range(rl + 2, 0)),
                 int'($urandom_range(rl + 2, 0)));
      finish_test("rand", 1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
